// File: rtl/sram_pio_pkg.sv
// Shared register map, FSM state type and count helpers for the pulse output PIO.
package sram_pio_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_LEN    = 2'd1;
  localparam logic [1:0] ADDR_PULSE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int LEN_W           = 16;

  typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_e;

  // A length of 0 is treated as 1, so the reload value never underflows.
  function automatic logic [LEN_W-1:0] reload_count(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - 16'd1;
  endfunction
endpackage

// File: rtl/sram_pulse_out_if.sv
// Avalon-MM slave bus bundle for the pulse output PIO.
interface sram_pulse_out_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sram_pulse_out_timer.sv
// One-shot pulse timer: holds the pulse mask high for max(len,1) cycles, retriggerable.
module sram_pulse_timer
  import sram_pio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trigger_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [WIDTH-1:0] pulse_mask_o,
  output logic             busy_o
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             fire;

  assign fire = trigger_i && (mask_i != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = PULSE;
          mask_d  = mask_i;
          count_d = reload_count(len_i);
        end
      end
      PULSE: begin
        // Retrigger wins over expiry on the same edge.
        if (fire) begin
          mask_d  = mask_q | mask_i;
          count_d = reload_count(len_i);
        end else if (count_q == '0) begin
          state_d = IDLE;
          mask_d  = '0;
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        count_d = '0;
      end
    endcase
  end

  assign pulse_mask_o = mask_q;
  assign busy_o       = (state_q == PULSE);
endmodule

// File: rtl/sram_pulse_out.sv
// Avalon-MM output PIO: static DATA register OR'd with a hardware one-shot pulse mask.
module sram_pulse_out
  import sram_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [15:0] DEFAULT_LEN = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  sram_pulse_out_if.slave  avs,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] pulse_mask;
  logic             busy;
  logic             wr_en;
  logic             trigger;

  assign wr_en   = avs.chipselect && !avs.write_n;
  assign trigger = wr_en && (avs.address == ADDR_PULSE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= '0;
      len_q   <= DEFAULT_LEN;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr_en) begin
      unique case (avs.address)
        ADDR_DATA: data_d = avs.writedata[WIDTH-1:0];
        ADDR_LEN:  len_d  = avs.writedata[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // No read strobe: the mux is sampled every cycle, giving latency-1 reads.
  always_comb begin
    rdata_d = '0;
    unique case (avs.address)
      ADDR_DATA:   rdata_d[WIDTH-1:0]      = data_q;
      ADDR_LEN:    rdata_d[LEN_W-1:0]      = len_q;
      ADDR_PULSE:  rdata_d[WIDTH-1:0]      = pulse_mask;
      ADDR_STATUS: rdata_d[STATUS_BUSY_BIT] = busy;
      default: ;
    endcase
  end

  sram_pulse_timer #(.WIDTH(WIDTH)) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .trigger_i    (trigger),
    .mask_i       (avs.writedata[WIDTH-1:0]),
    .len_i        (len_q),
    .pulse_mask_o (pulse_mask),
    .busy_o       (busy)
  );

  assign avs.readdata = rdata_q;
  assign out_port     = data_q | pulse_mask;
endmodule

// File: tb/tb_sram_pulse_out.sv
// Bench for sram_pulse_out: directed scenarios plus random bus traffic against a timestamp model.
module tb_sram_pulse_out;
  localparam int          W    = 8;
  localparam logic [15:0] DLEN = 16'd50000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] out_port;

  sram_pulse_out_if bus();

  sram_pulse_out #(.WIDTH(W), .DEFAULT_LEN(DLEN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: the pulse mask clears at an absolute cycle number; busy is simply "mask nonzero".
  logic [W-1:0]  m_data, m_mask;
  logic [15:0]   m_len;
  logic [31:0]   m_rd;
  longint        cyc = 0;
  longint        m_end = 0;

  always @(posedge clk) begin
    logic [31:0] wd;
    logic [W-1:0] nm;
    cyc++;
    wd = bus.writedata;
    nm = wd[W-1:0];
    if (!reset_n) begin
      m_data = '0; m_len = DLEN; m_mask = '0; m_rd = '0; m_end = 0;
    end else begin
      case (bus.address)
        2'd0: m_rd = {{(32-W){1'b0}}, m_data};
        2'd1: m_rd = {16'd0, m_len};
        2'd2: m_rd = {{(32-W){1'b0}}, m_mask};
        default: m_rd = {31'd0, (m_mask != '0)};
      endcase
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2 && nm != '0) begin
        m_mask = m_mask | nm;
        m_end  = cyc + ((m_len == 16'd0) ? 1 : longint'(m_len));
      end else if (m_mask != '0 && cyc == m_end) begin
        m_mask = '0;
      end
      if (bus.chipselect && !bus.write_n) begin
        if (bus.address == 2'd0) m_data = nm;
        if (bus.address == 2'd1) m_len  = wd[15:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_port", 32'(out_port), 32'(m_data | m_mask));
      chk("readdata", bus.readdata, m_rd);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address = a;
    @(posedge clk); #1;
    v = bus.readdata;
  endtask

  initial begin
    logic [31:0] v;
    int w0, w1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);
    reset_n = 1'b1;

    // reset values
    rd(2'd0, v); chk("rst_data", v, 32'h0);
    rd(2'd1, v); chk("rst_len", v, 32'h0000C350);
    rd(2'd2, v); chk("rst_pulse", v, 32'h0);
    rd(2'd3, v); chk("rst_status", v, 32'h0);
    chk("rst_out", 32'(out_port), 32'h0);

    // DATA register
    wr(2'd0, 32'h000000A5);
    chk("data_out", 32'(out_port), 32'hA5);
    rd(2'd0, v); chk("data_rd", v, 32'h000000A5);
    wr(2'd0, 32'hFFFFFFA5);
    rd(2'd0, v); chk("data_trunc", v, 32'h000000A5);
    wr(2'd0, 32'h0);

    // LEN=3 pulse width and status
    wr(2'd1, 32'd3);
    wr(2'd2, 32'h01);
    bus.address = 2'd3;
    w0 = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 1) chk("status_busy", bus.readdata, 32'h1);
      if (out_port[0]) w0++;
      idle(1);
    end
    chk("len3_width", 32'(w0), 32'd3);
    rd(2'd3, v); chk("status_idle", v, 32'h0);

    // LEN=0 behaves as 1
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h01);
    w0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_port[0]) w0++;
      idle(1);
    end
    chk("len0_width", 32'(w0), 32'd1);

    // retrigger five cycles later
    wr(2'd1, 32'd10);
    wr(2'd2, 32'h01);
    w0 = 0; w1 = 0;
    repeat (4) begin
      if (out_port[0]) w0++;
      if (out_port[1]) w1++;
      idle(1);
    end
    if (out_port[0]) w0++;
    if (out_port[1]) w1++;
    wr(2'd2, 32'h02);
    for (int k = 0; k < 30; k++) begin
      if (out_port[0]) w0++;
      if (out_port[1]) w1++;
      idle(1);
    end
    chk("retrig_bit0", 32'(w0), 32'd15);
    chk("retrig_bit1", 32'(w1), 32'd10);

    // data bit overlapping a pulse stays high; zero-mask write is ignored
    wr(2'd0, 32'h01);
    wr(2'd1, 32'd4);
    wr(2'd2, 32'h01);
    idle(2);
    chk("overlap_mid", 32'(out_port), 32'h01);
    idle(8);
    chk("overlap_after", 32'(out_port), 32'h01);
    wr(2'd2, 32'h0);
    rd(2'd3, v); chk("zero_mask_status", v, 32'h0);

    // reset mid-pulse with a concurrent trigger
    wr(2'd1, 32'd20);
    wr(2'd2, 32'h03);
    idle(3);
    reset_n = 1'b0;
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd2; bus.writedata = 32'h04;
    @(posedge clk); #1;
    chk("rst_mid_out", 32'(out_port), 32'h0);
    reset_n = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    rd(2'd3, v); chk("rst_mid_status", v, 32'h0);
    rd(2'd1, v); chk("rst_mid_len", v, 32'h0000C350);

    // random traffic, short lengths so pulses expire often
    for (int i = 0; i < 600; i++) begin
      logic [1:0] a;
      a = 2'($urandom_range(0, 3));
      bus.address    = a;
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 1) == 1);
      if (a == 2'd1)      bus.writedata = $urandom_range(0, 12);
      else if (a == 2'd2) bus.writedata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      else                bus.writedata = $urandom;
      reset_n = ($urandom_range(0, 80) != 0);
      @(posedge clk); #1;
    end
    reset_n = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
